// File: rtl/interface_demux_v1.sv
// rtl/interface_demux_v1.sv - egress demux: backend frame FIFOs to four MAC TX FIFOs with mask fan-out
// Optional per-port frame and drop statistics are built when IFDEMUX_STAT_EN is defined.
module interface_demux_v1 #(
  parameter int MAX_LEN = 1536,
  parameter int LEN_W   = 11
) (
  input  logic             clk_sys,
  input  logic             rstn_sys,
  output logic             ptr_fifo_rd,
  input  logic [19:0]      ptr_fifo_dout,
  input  logic             ptr_fifo_empty,
  output logic             data_fifo_rd,
  input  logic [7:0]       data_fifo_dout,
  output logic [3:0]       tx_data_fifo_wr,
  output logic [7:0]       tx_data_fifo_din,
  input  logic [3:0]       tx_data_fifo_afull,
  output logic [3:0]       tx_ptr_fifo_wr,
  output logic [15:0]      tx_ptr_fifo_din,
  input  logic [3:0]       tx_ptr_fifo_full,
`ifdef IFDEMUX_STAT_EN
  output logic             drop_pulse,
  output logic [63:0]      tx_frame_cnt,
  output logic [15:0]      drop_cnt
`else
  output logic             drop_pulse
`endif
);

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  typedef enum logic [7:0] {
    S_IDLE  = 8'h01,
    S_POP   = 8'h02,
    S_LATCH = 8'h04,
    S_WAIT  = 8'h08,
    S_XFER  = 8'h10,
    S_DRAIN = 8'h20,
    S_PTRWR = 8'h40,
    S_DROP  = 8'h80
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       src_q, src_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ptr_rd_q, ptr_rd_d;
  logic             data_rd_q, data_rd_d;
  logic             fwd_rd_q, fwd_rd_d;
  logic             byte_vld_q, byte_vld_d;
  logic [3:0]       tx_wr_q, tx_wr_d;
  logic [7:0]       tx_din_q, tx_din_d;
  logic [3:0]       ptr_wr_q, ptr_wr_d;
  logic [15:0]      ptr_din_q, ptr_din_d;
  logic             drop_q, drop_d;

  logic [3:0]       desc_mask;
  logic [3:0]       desc_src;
  logic [LEN_W-1:0] desc_len;
  logic             desc_bad;
  logic             unused_rsvd;

  assign desc_mask   = ptr_fifo_dout[19:16];
  assign desc_src    = ptr_fifo_dout[15:12];
  assign desc_len    = ptr_fifo_dout[LEN_W-1:0];
  assign unused_rsvd = ptr_fifo_dout[11];
  assign desc_bad    = (desc_mask == 4'd0) || (desc_len == '0) || (desc_len > MAX_LEN_V);

`ifdef IFDEMUX_STAT_EN
  logic [63:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    src_d     = src_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    ptr_rd_d  = 1'b0;
    data_rd_d = 1'b0;
    fwd_rd_d  = 1'b0;
    ptr_wr_d  = 4'd0;
    ptr_din_d = 16'd0;
    drop_d    = 1'b0;

    // A forwarded read lands on data_fifo_dout one cycle later and is registered out the cycle after.
    byte_vld_d = data_rd_q & fwd_rd_q;
    tx_wr_d    = byte_vld_q ? mask_q : 4'd0;
    tx_din_d   = byte_vld_q ? data_fifo_dout : tx_din_q;

    unique case (state_q)
      S_IDLE: begin
        if (!ptr_fifo_empty) begin
          state_d  = S_POP;
          ptr_rd_d = 1'b1;
        end
      end
      S_POP: state_d = S_LATCH;
      S_LATCH: begin
        mask_d = desc_mask;
        src_d  = desc_src;
        len_d  = desc_len;
        cnt_d  = LEN_W'(1);
        if (desc_bad) begin
          // Dropped frames are still read out so the data FIFO stays aligned to the next descriptor.
          state_d   = S_DROP;
          drop_d    = 1'b1;
          data_rd_d = (desc_len != '0);
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if ((mask_q & (tx_data_fifo_afull | tx_ptr_fifo_full)) == 4'd0) begin
          state_d   = S_XFER;
          data_rd_d = 1'b1;
          fwd_rd_d  = 1'b1;
        end
      end
      S_XFER: begin
        if (cnt_q == len_q) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d     = cnt_q + LEN_W'(1);
          data_rd_d = 1'b1;
          fwd_rd_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        state_d   = S_PTRWR;
        ptr_wr_d  = mask_q;
        ptr_din_d = {src_q, 1'b0, len_q};
      end
      S_PTRWR: state_d = S_IDLE;
      S_DROP: begin
        if ((len_q == '0) || (cnt_q == len_q)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d     = cnt_q + LEN_W'(1);
          data_rd_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef IFDEMUX_STAT_EN
    frame_cnt_d = frame_cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (ptr_wr_d[i]) begin
        frame_cnt_d[i*16 +: 16] = frame_cnt_q[i*16 +: 16] + 16'd1;
      end
    end
    drop_cnt_d = drop_d ? (drop_cnt_q + 16'd1) : drop_cnt_q;
`endif
  end

  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      state_q    <= S_IDLE;
      mask_q     <= 4'd0;
      src_q      <= 4'd0;
      len_q      <= '0;
      cnt_q      <= '0;
      ptr_rd_q   <= 1'b0;
      data_rd_q  <= 1'b0;
      fwd_rd_q   <= 1'b0;
      byte_vld_q <= 1'b0;
      tx_wr_q    <= 4'd0;
      tx_din_q   <= 8'd0;
      ptr_wr_q   <= 4'd0;
      ptr_din_q  <= 16'd0;
      drop_q     <= 1'b0;
`ifdef IFDEMUX_STAT_EN
      frame_cnt_q <= 64'd0;
      drop_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      src_q      <= src_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      ptr_rd_q   <= ptr_rd_d;
      data_rd_q  <= data_rd_d;
      fwd_rd_q   <= fwd_rd_d;
      byte_vld_q <= byte_vld_d;
      tx_wr_q    <= tx_wr_d;
      tx_din_q   <= tx_din_d;
      ptr_wr_q   <= ptr_wr_d;
      ptr_din_q  <= ptr_din_d;
      drop_q     <= drop_d;
`ifdef IFDEMUX_STAT_EN
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  assign ptr_fifo_rd      = ptr_rd_q;
  assign data_fifo_rd     = data_rd_q;
  assign tx_data_fifo_wr  = tx_wr_q;
  assign tx_data_fifo_din = tx_din_q;
  assign tx_ptr_fifo_wr   = ptr_wr_q;
  assign tx_ptr_fifo_din  = ptr_din_q;
  assign drop_pulse       = drop_q;
`ifdef IFDEMUX_STAT_EN
  assign tx_frame_cnt = frame_cnt_q;
  assign drop_cnt     = drop_cnt_q;
`endif

endmodule

// File: tb/tb_interface_demux_v1.sv
// tb/tb_interface_demux_v1.sv - scoreboard bench for interface_demux_v1 with backend FIFO models
// Builds with or without IFDEMUX_STAT_EN.
module tb_interface_demux_v1;

  logic        clk_sys = 1'b0;
  logic        rstn_sys;
  logic        ptr_fifo_rd;
  logic [19:0] ptr_fifo_dout;
  logic        ptr_fifo_empty;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_dout;
  logic [3:0]  tx_data_fifo_wr;
  logic [7:0]  tx_data_fifo_din;
  logic [3:0]  tx_data_fifo_afull;
  logic [3:0]  tx_ptr_fifo_wr;
  logic [15:0] tx_ptr_fifo_din;
  logic [3:0]  tx_ptr_fifo_full;
  logic        drop_pulse;
`ifdef IFDEMUX_STAT_EN
  logic [63:0] tx_frame_cnt;
  logic [15:0] drop_cnt;
`endif

  always #5 clk_sys = ~clk_sys;

  interface_demux_v1 dut (
    .clk_sys(clk_sys),
    .rstn_sys(rstn_sys),
    .ptr_fifo_rd(ptr_fifo_rd),
    .ptr_fifo_dout(ptr_fifo_dout),
    .ptr_fifo_empty(ptr_fifo_empty),
    .data_fifo_rd(data_fifo_rd),
    .data_fifo_dout(data_fifo_dout),
    .tx_data_fifo_wr(tx_data_fifo_wr),
    .tx_data_fifo_din(tx_data_fifo_din),
    .tx_data_fifo_afull(tx_data_fifo_afull),
    .tx_ptr_fifo_wr(tx_ptr_fifo_wr),
    .tx_ptr_fifo_din(tx_ptr_fifo_din),
    .tx_ptr_fifo_full(tx_ptr_fifo_full),
    .drop_pulse(drop_pulse)
`ifdef IFDEMUX_STAT_EN
    , .tx_frame_cnt(tx_frame_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  // Backend FIFOs in standard mode: dout updates on the edge that samples rd.
  logic [19:0] pmem [0:255];
  logic [7:0]  dmem [0:65535];
  int p_wr, p_rd, d_wr, d_rd;

  assign ptr_fifo_empty = (p_rd == p_wr);

  always @(posedge clk_sys) begin
    if (!rstn_sys) begin
      p_rd           <= p_wr;
      d_rd           <= d_wr;
      ptr_fifo_dout  <= '0;
      data_fifo_dout <= '0;
    end else begin
      if (ptr_fifo_rd) begin
        ptr_fifo_dout <= pmem[p_rd & 255];
        p_rd          <= p_rd + 1;
      end
      if (data_fifo_rd) begin
        data_fifo_dout <= dmem[d_rd & 65535];
        d_rd           <= d_rd + 1;
      end
    end
  end

  // Expected events: {kind, port mask, value}; kind 0 = data byte, 1 = pointer entry, 2 = drop.
  logic [21:0] exp_q [$];
  int          pop_times [$];
  int tests_run, tests_failed;
  int cyc, n_rd, n_dwr, n_pwr, n_drop;
  int b_rd, b_dwr, b_pwr, b_drop;
  bit bp_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [21:0] act);
    if (exp_q.size() == 0) begin
      chk({name, "_unexpected"}, {42'd0, act}, 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      chk(name, {42'd0, act}, {42'd0, exp_q.pop_front()});
    end
  endtask

  // Reference model: a frame is forwarded only if it targets a port and its length is 1..1536.
  task automatic push_desc(input logic [3:0] mask, input logic [3:0] src, input int len, input bit inc);
    logic [10:0] l;
    logic [7:0]  b;
    bit          fwd;
    l   = len[10:0];
    fwd = (mask != 4'd0) && (len > 0) && (len <= 1536);
    pmem[p_wr & 255] = {mask, src, 1'b0, l};
    if (!fwd) exp_q.push_back({2'd2, 4'd0, 16'd0});
    for (int i = 0; i < len; i++) begin
      b = inc ? i[7:0] : 8'($urandom);
      dmem[d_wr & 65535] = b;
      d_wr++;
      if (fwd) exp_q.push_back({2'd0, mask, 8'd0, b});
    end
    if (fwd) exp_q.push_back({2'd1, mask, src, 1'b0, l});
    p_wr++;
  endtask

  task automatic snap();
    b_rd = n_rd; b_dwr = n_dwr; b_pwr = n_pwr; b_drop = n_drop;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && p_rd == p_wr && d_rd == d_wr) && t < 6000) begin
      @(negedge clk_sys);
      t++;
    end
    chk({name, "_idle_timeout"}, 64'(t < 6000), 64'd1);
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic chk_counts(input string name, input int rd, input int dwr, input int pwr, input int drp);
    chk({name, "_reads"}, 64'(n_rd - b_rd), 64'(rd));
    chk({name, "_data_wr"}, 64'(n_dwr - b_dwr), 64'(dwr));
    chk({name, "_ptr_wr"}, 64'(n_pwr - b_pwr), 64'(pwr));
    chk({name, "_drops"}, 64'(n_drop - b_drop), 64'(drp));
  endtask

  initial begin
    int total, len, t;
    bit seen;
    logic [3:0] m;
`ifdef IFDEMUX_STAT_EN
    logic [15:0] c0;
`endif
    tests_run = 0; tests_failed = 0;
    cyc = 0; n_rd = 0; n_dwr = 0; n_pwr = 0; n_drop = 0;
    p_wr = 0; d_wr = 0; bp_en = 1'b0;
    rstn_sys = 1'b0;
    tx_data_fifo_afull = 4'd0;
    tx_ptr_fifo_full   = 4'd0;

    fork
      forever begin
        @(negedge clk_sys);
        cyc++;
        if (!rstn_sys) begin
          exp_q.delete();
          continue;
        end
        if (data_fifo_rd) n_rd++;
        if (ptr_fifo_rd) pop_times.push_back(cyc);
        if (tx_data_fifo_wr != 4'd0) begin
          n_dwr++;
          sb_check("data_wr", {2'd0, tx_data_fifo_wr, 8'd0, tx_data_fifo_din});
        end
        if (tx_ptr_fifo_wr != 4'd0) begin
          n_pwr++;
          sb_check("ptr_wr", {2'd1, tx_ptr_fifo_wr, tx_ptr_fifo_din});
        end
        if (drop_pulse) begin
          n_drop++;
          sb_check("drop", {2'd2, 4'd0, 16'd0});
        end
      end
      forever begin
        @(negedge clk_sys);
        if (bp_en) begin
          tx_data_fifo_afull = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
          tx_ptr_fifo_full   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
        end
      end
    join_none

    repeat (4) @(negedge clk_sys);
    chk("reset_outputs", {29'd0, ptr_fifo_rd, data_fifo_rd, tx_data_fifo_wr, tx_data_fifo_din,
        tx_ptr_fifo_wr, tx_ptr_fifo_din, drop_pulse}, 64'd0);
    rstn_sys = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Unicast, incrementing payload
    snap();
    push_desc(4'b0010, 4'b0001, 64, 1'b1);
    wait_idle("unicast");
    chk_counts("unicast", 64, 64, 1, 0);

    // Multicast held off by one targeted port
    snap();
    tx_data_fifo_afull = 4'b0100;
    push_desc(4'b1101, 4'b0100, 100, 1'b0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk_sys);
      if (data_fifo_rd) seen = 1'b1;
    end
    chk("bp_no_read", 64'(seen), 64'd0);
    tx_data_fifo_afull = 4'd0;
    wait_idle("mcast");
    chk_counts("mcast", 100, 100, 1, 0);

    // Drop on empty mask, then a valid frame must stay aligned
    snap();
`ifdef IFDEMUX_STAT_EN
    c0 = drop_cnt;
`endif
    push_desc(4'b0000, 4'b0010, 60, 1'b0);
    push_desc(4'b0100, 4'b1000, 20, 1'b0);
    wait_idle("drop_mask");
    chk_counts("drop_mask", 80, 20, 1, 1);
`ifdef IFDEMUX_STAT_EN
    chk("stat_drop_cnt", 64'(drop_cnt - c0), 64'd1);
`endif

    // Length boundaries
    snap();
    push_desc(4'b0001, 4'b0001, 0, 1'b0);
    wait_idle("len0");
    chk_counts("len0", 0, 0, 0, 1);
    snap();
    push_desc(4'b0001, 4'b0001, 1537, 1'b0);
    wait_idle("len1537");
    chk_counts("len1537", 1537, 0, 0, 1);
    snap();
    push_desc(4'b1000, 4'b0010, 1536, 1'b0);
    wait_idle("len1536");
    chk_counts("len1536", 1536, 1536, 1, 0);

    // Back-to-back queue of eight frames
    snap();
    pop_times.delete();
`ifdef IFDEMUX_STAT_EN
    c0 = tx_frame_cnt[31:16];
`endif
    for (int i = 0; i < 8; i++) push_desc(4'b0010, 4'b0001, 60, 1'b0);
    wait_idle("b2b");
    chk_counts("b2b", 480, 480, 8, 0);
    chk("b2b_pops", 64'(pop_times.size()), 64'd8);
    for (int i = 1; i < 8 && i < pop_times.size(); i++) begin
      chk("b2b_spacing", 64'(pop_times[i] - pop_times[i-1]), 64'd66);
    end
`ifdef IFDEMUX_STAT_EN
    chk("stat_frame_cnt_p1", 64'(tx_frame_cnt[31:16] - c0), 64'd8);
`endif

    // Randomized frames under random backpressure
    snap();
    total = 0;
    bp_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      m   = 4'($urandom_range(0, 15));
      len = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 90));
      total += len;
      push_desc(m, 4'b0001 << $urandom_range(0, 3), len, 1'b0);
      repeat ($urandom_range(0, 100)) @(negedge clk_sys);
    end
    wait_idle("random");
    bp_en = 1'b0;
    tx_data_fifo_afull = 4'd0;
    tx_ptr_fifo_full   = 4'd0;
    chk("random_reads", 64'(n_rd - b_rd), 64'(total));

    // Reset in the middle of a transfer
    snap();
    push_desc(4'b0010, 4'b0001, 64, 1'b1);
    t = 0;
    while ((n_dwr - b_dwr) < 30 && t < 500) begin
      @(negedge clk_sys);
      t++;
    end
    chk("midreset_reach_byte30", 64'(t < 500), 64'd1);
    rstn_sys = 1'b0;
    #1;
    chk("midreset_outputs", {29'd0, ptr_fifo_rd, data_fifo_rd, tx_data_fifo_wr, tx_data_fifo_din,
        tx_ptr_fifo_wr, tx_ptr_fifo_din, drop_pulse}, 64'd0);
    repeat (3) @(negedge clk_sys);
    rstn_sys = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk_sys);
      if (ptr_fifo_rd || data_fifo_rd || tx_data_fifo_wr != 0 || tx_ptr_fifo_wr != 0 || drop_pulse) seen = 1'b1;
    end
    chk("midreset_quiet", 64'(seen), 64'd0);
    snap();
    push_desc(4'b0001, 4'b0010, 10, 1'b0);
    @(negedge clk_sys);
    chk("midreset_idle_pop", 64'(ptr_fifo_rd), 64'd1);
    wait_idle("post_reset");
    chk_counts("post_reset", 10, 10, 1, 0);

    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
